// File: rtl/qsys_serial_arbiter.sv
// Round-robin arbiter sharing one serial device slave among four Avalon-MM requesters.
// One transaction in flight at a time; reads are guarded by a timeout that returns 32'hDEADBEEF.
module qsys_serial_arbiter #(
  parameter int RD_TIMEOUT = 255
) (
  input  logic         csi_MCLK_clk,
  input  logic         rsi_MRST_reset_n,
  input  logic [3:0]   avs_req_write,
  input  logic [3:0]   avs_req_read,
  input  logic [31:0]  avs_req_address,
  input  logic [127:0] avs_req_writedata,
  output logic [3:0]   avs_req_waitrequest,
  output logic [31:0]  avs_req_readdata,
  output logic [3:0]   avs_req_readdatavalid,
  output logic [7:0]   avm_ser_address,
  output logic [31:0]  avm_ser_writedata,
  output logic         avm_ser_write,
  output logic         avm_ser_read,
  input  logic         avm_ser_waitrequest,
  input  logic [31:0]  avm_ser_readdata,
  input  logic         avm_ser_readdatavalid,
  output logic         err_timeout,
  input  logic         err_clear
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  state_t      state_reg;
  logic [1:0]  gnt_reg;
  logic [1:0]  last_gnt_reg;
  logic [15:0] cnt_reg;

  logic [3:0]  pending;
  logic [7:0]  addr_slice  [4];
  logic [31:0] wdata_slice [4];
  logic        sel_valid;
  logic [1:0]  sel_idx;
  logic [1:0]  cand;
  logic [16:0] cnt_inc;
  logic        timeout_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_req
      assign pending[gi]     = avs_req_write[gi] | avs_req_read[gi];
      assign addr_slice[gi]  = avs_req_address[8*gi +: 8];
      assign wdata_slice[gi] = avs_req_writedata[32*gi +: 32];
      assign avs_req_waitrequest[gi] =
        !((state_reg == ISSUE) && (gnt_reg == 2'(gi)) && !avm_ser_waitrequest);
    end
  endgenerate

  // Scan from last_gnt+4 down to last_gnt+1 so the nearest pending requester is kept.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = last_gnt_reg;
    cand      = last_gnt_reg;
    for (int k = 4; k >= 1; k--) begin
      cand = last_gnt_reg + 2'(k);
      if (pending[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign cnt_inc     = {1'b0, cnt_reg} + 17'd1;
  assign timeout_hit = (cnt_inc == 17'(RD_TIMEOUT));

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      state_reg             <= IDLE;
      gnt_reg               <= 2'd0;
      last_gnt_reg          <= 2'd3;
      cnt_reg               <= 16'd0;
      avm_ser_write         <= 1'b0;
      avm_ser_read          <= 1'b0;
      avm_ser_address       <= 8'd0;
      avm_ser_writedata     <= 32'd0;
      avs_req_readdata      <= 32'd0;
      avs_req_readdatavalid <= 4'd0;
      err_timeout           <= 1'b0;
    end else begin
      // A timeout assignment later in this block overrides the clear.
      if (err_clear) err_timeout <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (sel_valid) begin
            gnt_reg           <= sel_idx;
            last_gnt_reg      <= sel_idx;
            avm_ser_address   <= addr_slice[sel_idx];
            avm_ser_writedata <= wdata_slice[sel_idx];
            avm_ser_write     <= avs_req_write[sel_idx];
            avm_ser_read      <= !avs_req_write[sel_idx];
            state_reg         <= ISSUE;
          end
        end
        ISSUE: begin
          if (!avm_ser_waitrequest) begin
            avm_ser_write <= 1'b0;
            avm_ser_read  <= 1'b0;
            cnt_reg       <= 16'd0;
            state_reg     <= avm_ser_write ? IDLE : WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (avm_ser_readdatavalid) begin
            avs_req_readdata      <= avm_ser_readdata;
            avs_req_readdatavalid <= 4'b0001 << gnt_reg;
            state_reg             <= RESP;
          end else if (timeout_hit) begin
            avs_req_readdata      <= 32'hDEADBEEF;
            avs_req_readdatavalid <= 4'b0001 << gnt_reg;
            err_timeout           <= 1'b1;
            state_reg             <= RESP;
          end else begin
            cnt_reg <= cnt_inc[15:0];
          end
        end
        RESP: begin
          avs_req_readdatavalid <= 4'd0;
          state_reg             <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qsys_serial_arbiter.sv
// Scoreboard bench: expected device commands and requester responses are queued at stimulus time
// and popped when the arbiter presents them; a second instance exercises the short read timeout.
module tb_qsys_serial_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [3:0]   req_write, req_read;
  logic [31:0]  req_address;
  logic [127:0] req_writedata;
  logic [3:0]   req_waitreq, req_rdv;
  logic [31:0]  req_rdata;
  logic [7:0]   ser_address;
  logic [31:0]  ser_writedata;
  logic         ser_write, ser_read;
  logic         ser_wait;
  logic [31:0]  ser_rdata;
  logic         ser_rdv;
  logic         err_to, err_clear;

  logic [3:0]   t_req_write, t_req_read;
  logic [31:0]  t_req_address;
  logic [127:0] t_req_writedata;
  logic [3:0]   t_waitreq, t_rdv;
  logic [31:0]  t_rdata;
  logic [7:0]   t_ser_address;
  logic [31:0]  t_ser_writedata;
  logic         t_ser_write, t_ser_read;
  logic         t_ser_wait;
  logic [31:0]  t_ser_rdata;
  logic         t_ser_rdv;
  logic         t_err, t_err_clear;

  qsys_serial_arbiter dut (
    .csi_MCLK_clk(clk), .rsi_MRST_reset_n(rst_n),
    .avs_req_write(req_write), .avs_req_read(req_read),
    .avs_req_address(req_address), .avs_req_writedata(req_writedata),
    .avs_req_waitrequest(req_waitreq), .avs_req_readdata(req_rdata),
    .avs_req_readdatavalid(req_rdv),
    .avm_ser_address(ser_address), .avm_ser_writedata(ser_writedata),
    .avm_ser_write(ser_write), .avm_ser_read(ser_read),
    .avm_ser_waitrequest(ser_wait), .avm_ser_readdata(ser_rdata),
    .avm_ser_readdatavalid(ser_rdv),
    .err_timeout(err_to), .err_clear(err_clear)
  );

  qsys_serial_arbiter #(.RD_TIMEOUT(8)) dut_to (
    .csi_MCLK_clk(clk), .rsi_MRST_reset_n(rst_n),
    .avs_req_write(t_req_write), .avs_req_read(t_req_read),
    .avs_req_address(t_req_address), .avs_req_writedata(t_req_writedata),
    .avs_req_waitrequest(t_waitreq), .avs_req_readdata(t_rdata),
    .avs_req_readdatavalid(t_rdv),
    .avm_ser_address(t_ser_address), .avm_ser_writedata(t_ser_writedata),
    .avm_ser_write(t_ser_write), .avm_ser_read(t_ser_read),
    .avm_ser_waitrequest(t_ser_wait), .avm_ser_readdata(t_ser_rdata),
    .avm_ser_readdatavalid(t_ser_rdv),
    .err_timeout(t_err), .err_clear(t_err_clear)
  );

  typedef struct packed {
    logic [1:0]  gnt;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } cmd_t;

  typedef struct packed {
    logic [3:0]  rdv;
    logic [31:0] data;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // device model state
  int          dev_wait  = 0;
  int          dev_delay = 0;
  logic [31:0] dev_data  = 32'h0;
  int          wcnt = 0, rd_cnt = 0;
  bit          acc_pend = 0, acc_read = 0, rd_active = 0;
  bit          acc_seen = 0;
  logic [1:0]  acc_gnt = 2'd0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_cmd(input logic [1:0] g, input logic wr, input logic [7:0] a, input logic [31:0] d);
    cmd_t c;
    c.gnt = g; c.wr = wr; c.addr = a; c.data = d;
    cmd_q.push_back(c);
  endtask

  task automatic push_rsp(input logic [3:0] v, input logic [31:0] d);
    rsp_t r;
    r.rdv = v; r.data = d;
    rsp_q.push_back(r);
  endtask

  // One clock: update the device model at the falling edge, then check the main DUT 1 time unit later.
  task automatic tick();
    cmd_t       ce;
    rsp_t       re;
    logic [3:0] exp_wr;
    bit         rdv_drv;
    @(negedge clk);
    rdv_drv = ser_rdv;
    if (!rst_n) begin
      wcnt = 0; acc_pend = 0; rd_active = 0;
      ser_wait = 1'b1; ser_rdv = 1'b0;
    end else begin
      ser_rdv = 1'b0;
      if (rd_active) begin
        rd_cnt--;
        if (rd_cnt == 0) begin ser_rdv = 1'b1; ser_rdata = dev_data; rd_active = 0; end
      end
      if (acc_pend) begin
        acc_pend = 0;
        if (acc_read && dev_delay > 1) begin rd_active = 1; rd_cnt = dev_delay - 1; end
      end
      ser_wait = 1'b1;
      if (ser_write || ser_read) begin
        if (wcnt == dev_wait) begin ser_wait = 1'b0; wcnt = 0; end
        else wcnt++;
      end
    end
    #1;
    acc_seen = 0;
    if (rdv_drv) begin
      if (rsp_q.size() == 0) check_val("rsp_unexpected", 64'(req_rdv), 64'h0);
      else begin
        re = rsp_q.pop_front();
        check_val("rsp", {28'h0, req_rdv, req_rdata}, {28'h0, re.rdv, re.data});
      end
    end else begin
      check_val("rdv_idle", 64'(req_rdv), 64'h0);
    end
    if ((ser_write || ser_read) && !ser_wait) begin
      acc_seen = 1; acc_pend = 1; acc_read = ser_read;
      if (cmd_q.size() == 0) check_val("cmd_unexpected", {62'h0, ser_write, ser_read}, 64'h0);
      else begin
        ce = cmd_q.pop_front();
        acc_gnt = ce.gnt;
        check_val("cmd", {22'h0, ser_write, ser_read, ser_address, (ce.wr ? ser_writedata : 32'h0)},
                         {22'h0, ce.wr, !ce.wr, ce.addr, (ce.wr ? ce.data : 32'h0)});
        exp_wr = ~(4'b0001 << ce.gnt);
        check_val("waitreq_acc", 64'(req_waitreq), 64'(exp_wr));
      end
    end else begin
      check_val("waitreq_idle", 64'(req_waitreq), 64'hF);
    end
  endtask

  task automatic run_accepts(input int n, input bit drop, input int budget);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < budget) begin
      tick();
      cyc++;
      if (acc_seen) begin
        seen++;
        if (drop) begin req_write[acc_gnt] = 1'b0; req_read[acc_gnt] = 1'b0; end
      end
    end
    if (seen < n) check_val("accept_budget", 64'(seen), 64'(n));
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [31:0] d);
    req_address[8*i +: 8]    = a;
    req_writedata[32*i +: 32] = d;
  endtask

  // Issue a read on the timeout instance and return once its command is on the bus.
  task automatic t_start_read(input int i, input logic [7:0] a);
    int cyc = 0;
    t_req_read[i] = 1'b1;
    t_req_address[8*i +: 8] = a;
    tick();
    while (!t_ser_read && cyc < 10) begin tick(); cyc++; end
    if (!t_ser_read) check_val("t_issue_budget", 64'h0, 64'h1);
    t_req_read = 4'h0;
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    req_write = 4'h0; req_read = 4'h0; req_address = 32'h0; req_writedata = 128'h0;
    ser_wait = 1'b1; ser_rdata = 32'h0; ser_rdv = 1'b0; err_clear = 1'b0;
    t_req_write = 4'h0; t_req_read = 4'h0; t_req_address = 32'h0; t_req_writedata = 128'h0;
    t_ser_wait = 1'b0; t_ser_rdata = 32'h0; t_ser_rdv = 1'b0; t_err_clear = 1'b0;

    repeat (3) tick();
    check_val("rst_waitreq", 64'(req_waitreq), 64'hF);
    check_val("rst_cmd", {22'h0, ser_write, ser_read, ser_address, ser_writedata}, 64'h0);
    check_val("rst_rdata", {27'h0, err_to, req_rdv, req_rdata}, 64'h0);
    rst_n = 1'b1;

    // Round-robin from reset with all four requesters writing continuously.
    dev_wait = 0;
    for (int i = 0; i < 4; i++) set_req(i, 8'h80 + 8'(i), 32'h1000_0000 + 32'(i));
    for (int i = 0; i < 5; i++) push_cmd(2'(i % 4), 1'b1, 8'h80 + 8'(i % 4), 32'h1000_0000 + 32'(i % 4));
    req_write = 4'hF;
    run_accepts(5, 1'b0, 60);
    req_write = 4'h0;
    repeat (3) tick();

    // Single write from requester 2 with 3 device wait cycles.
    dev_wait = 3;
    set_req(2, 8'h10, 32'h1234_5678);
    push_cmd(2'd2, 1'b1, 8'h10, 32'h1234_5678);
    req_write[2] = 1'b1;
    run_accepts(1, 1'b1, 30);
    repeat (2) tick();
    check_val("write_idle", {62'h0, ser_write, ser_read}, 64'h0);

    // Read from requester 1; data returns 70 cycles after accept.
    dev_wait = 1; dev_delay = 70; dev_data = 32'hCAFE_F00D;
    set_req(1, 8'h04, 32'h0);
    push_cmd(2'd1, 1'b0, 8'h04, 32'h0);
    push_rsp(4'b0010, 32'hCAFE_F00D);
    req_read[1] = 1'b1;
    run_accepts(1, 1'b1, 30);
    cyc = 0;
    while (rsp_q.size() != 0 && cyc < 120) begin tick(); cyc++; end
    check_val("read_rsp_seen", 64'(rsp_q.size()), 64'h0);
    repeat (3) tick();

    // Requester 3 asserts write and read together, then drops them while the command waits.
    dev_wait = 2;
    set_req(3, 8'h3C, 32'h0BAD_C0DE);
    push_cmd(2'd3, 1'b1, 8'h3C, 32'h0BAD_C0DE);
    req_write[3] = 1'b1; req_read[3] = 1'b1;
    cyc = 0;
    tick();
    while (!(ser_write || ser_read) && cyc < 10) begin tick(); cyc++; end
    req_write[3] = 1'b0; req_read[3] = 1'b0;
    run_accepts(1, 1'b0, 20);
    repeat (3) tick();

    // Reset asserted while a read from requester 2 is outstanding.
    dev_wait = 0; dev_delay = 0;
    set_req(2, 8'h44, 32'h0);
    push_cmd(2'd2, 1'b0, 8'h44, 32'h0);
    req_read[2] = 1'b1;
    run_accepts(1, 1'b1, 20);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_waitreq", 64'(req_waitreq), 64'hF);
    check_val("midrst_cmd", {22'h0, ser_write, ser_read, ser_address, ser_writedata}, 64'h0);
    check_val("midrst_rdata", {27'h0, err_to, req_rdv, req_rdata}, 64'h0);
    cmd_q.delete();
    rsp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    dev_wait = 1;
    set_req(0, 8'h50, 32'hA000_0000);
    set_req(2, 8'h52, 32'hA000_0002);
    push_cmd(2'd0, 1'b1, 8'h50, 32'hA000_0000);
    push_cmd(2'd2, 1'b1, 8'h52, 32'hA000_0002);
    req_write[0] = 1'b1; req_write[2] = 1'b1;
    run_accepts(2, 1'b1, 40);
    repeat (3) tick();
    check_val("cmd_q_empty", 64'(cmd_q.size()), 64'h0);

    // Timeout instance (RD_TIMEOUT=8): device never answers.
    t_start_read(0, 8'h20);
    cyc = 0;
    tick();
    while (t_rdv == 4'h0 && cyc < 50) begin cyc++; tick(); end
    check_val("to_cycles", 64'(cyc), 64'd8);
    check_val("to_rsp", {28'h0, t_rdv, t_rdata}, {28'h0, 4'b0001, 32'hDEAD_BEEF});
    check_val("to_err_set", 64'(t_err), 64'h1);
    tick();
    check_val("to_rdv_pulse", 64'(t_rdv), 64'h0);
    t_ser_rdv = 1'b1; t_ser_rdata = 32'h5555_5555;
    tick();
    t_ser_rdv = 1'b0;
    tick();
    check_val("to_late_ignored", {27'h0, t_err, t_rdv, t_rdata}, {27'h1, 4'h0, 32'hDEAD_BEEF});
    t_err_clear = 1'b1;
    tick();
    t_err_clear = 1'b0;
    check_val("to_err_clear", 64'(t_err), 64'h0);

    // Read data arriving on the exact timeout cycle wins.
    t_start_read(1, 8'h24);
    repeat (8) tick();
    t_ser_rdv = 1'b1; t_ser_rdata = 32'hA5A5_0001;
    tick();
    t_ser_rdv = 1'b0;
    check_val("to_race_rsp", {27'h0, t_err, t_rdv, t_rdata}, {27'h0, 4'b0010, 32'hA5A5_0001});

    // Timeout setting err_timeout while err_clear is held: set wins, clear applies next cycle.
    t_err_clear = 1'b1;
    t_start_read(2, 8'h28);
    cyc = 0;
    tick();
    while (t_rdv == 4'h0 && cyc < 50) begin cyc++; tick(); end
    check_val("to_set_wins", {27'h0, t_err, t_rdv, t_rdata}, {27'h1, 4'b0100, 32'hDEAD_BEEF});
    tick();
    check_val("to_clear_after", 64'(t_err), 64'h0);
    t_err_clear = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
